// File: rtl/shield_pkg.sv
// Shared types and widths for the shield read-side arbitration logic.
package shield_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam int unsigned SHIELD_IV_WIDTH = 64;
  localparam int unsigned STAT_WIDTH      = 32;

endpackage

// File: rtl/shield_read_decrypt_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req searching
// upward from last+1, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         any
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(last) + 32'd1 + i) % N;
      if (!any && req[idx]) begin
        grant = W'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shield_read_decrypt_arbiter.sv
// Round-robin sharing of one non-pipelined shield_read_decryptor between
// NUM_REQ read requesters. Grant counters exist only with SHIELD_DECRYPT_ARB_STATS_EN.
module shield_read_decrypt_arbiter
  import shield_pkg::*;
#(
  parameter int NUM_REQ              = 4,
  parameter int REQ_ID_WIDTH         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int SHIELD_ADDR_WIDTH    = 32,
  parameter int SHIELD_COUNTER_WIDTH = 32,
  parameter int LINE_WIDTH           = 512,
  parameter int HMAC_TAG_WIDTH       = 128
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ*LINE_WIDTH-1:0]           up_req_data,
  input  logic [NUM_REQ*SHIELD_ADDR_WIDTH-1:0]    up_req_addr,
  input  logic [NUM_REQ*SHIELD_COUNTER_WIDTH-1:0] up_req_counter,
  input  logic [NUM_REQ*SHIELD_IV_WIDTH-1:0]      up_req_iv,
  input  logic [NUM_REQ-1:0]                      up_req_val,
  output logic [NUM_REQ-1:0]                      up_req_rdy,
  output logic [LINE_WIDTH-1:0]                   up_resp_pad,
  output logic [HMAC_TAG_WIDTH-1:0]               up_resp_hmac_tag,
  output logic [NUM_REQ-1:0]                      up_resp_val,
  input  logic [NUM_REQ-1:0]                      up_resp_rdy,
  output logic [LINE_WIDTH-1:0]                   dec_req_data,
  output logic [SHIELD_ADDR_WIDTH-1:0]            dec_req_addr,
  output logic [SHIELD_COUNTER_WIDTH-1:0]         dec_req_counter,
  output logic [SHIELD_IV_WIDTH-1:0]              dec_req_iv,
  output logic                                    dec_req_val,
  input  logic                                    dec_req_rdy,
  input  logic [LINE_WIDTH-1:0]                   dec_resp_pad,
  input  logic [HMAC_TAG_WIDTH-1:0]               dec_resp_hmac_tag,
  input  logic                                    dec_resp_val,
  output logic                                    dec_resp_rdy,
  output logic                                    busy,
  output logic [NUM_REQ*STAT_WIDTH-1:0]           stat_grants
);

  arb_state_e              state, state_next;
  logic [REQ_ID_WIDTH-1:0] grant_r, last_r, pick_idx;
  logic                    pick_any;

  rr_pick #(.N(NUM_REQ), .W(REQ_ID_WIDTH)) u_pick (
    .req   (up_req_val),
    .last  (last_r),
    .grant (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      grant_r <= '0;
      last_r  <= REQ_ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state <= state_next;
      if (state == ARB_IDLE && pick_any)
        grant_r <= pick_idx;
      if (state == ARB_WAIT && dec_resp_val && dec_resp_rdy)
        last_r <= grant_r;
    end
  end

  // Request fields are muxed unconditionally; only the valid is state-gated.
  assign dec_req_data     = up_req_data[grant_r*LINE_WIDTH +: LINE_WIDTH];
  assign dec_req_addr     = up_req_addr[grant_r*SHIELD_ADDR_WIDTH +: SHIELD_ADDR_WIDTH];
  assign dec_req_counter  = up_req_counter[grant_r*SHIELD_COUNTER_WIDTH +: SHIELD_COUNTER_WIDTH];
  assign dec_req_iv       = up_req_iv[grant_r*SHIELD_IV_WIDTH +: SHIELD_IV_WIDTH];
  assign up_resp_pad      = dec_resp_pad;
  assign up_resp_hmac_tag = dec_resp_hmac_tag;
  assign busy             = (state != ARB_IDLE);

  always_comb begin
    state_next   = state;
    dec_req_val  = 1'b0;
    dec_resp_rdy = 1'b0;
    up_req_rdy   = '0;
    up_resp_val  = '0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) state_next = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        dec_req_val         = up_req_val[grant_r];
        up_req_rdy[grant_r] = dec_req_rdy;
        if (dec_req_val && dec_req_rdy) state_next = ARB_WAIT;
      end
      ARB_WAIT: begin
        up_resp_val[grant_r] = dec_resp_val;
        dec_resp_rdy         = up_resp_rdy[grant_r];
        if (dec_resp_val && dec_resp_rdy) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

`ifdef SHIELD_DECRYPT_ARB_STATS_EN
  logic [NUM_REQ*STAT_WIDTH-1:0] stat_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_r <= '0;
    end else if (state == ARB_ISSUE && dec_req_val && dec_req_rdy &&
                 stat_r[grant_r*STAT_WIDTH +: STAT_WIDTH] != '1) begin
      stat_r[grant_r*STAT_WIDTH +: STAT_WIDTH] <=
        stat_r[grant_r*STAT_WIDTH +: STAT_WIDTH] + STAT_WIDTH'(1);
    end
  end

  assign stat_grants = stat_r;
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_shield_read_decrypt_arbiter.sv
// Directed plus randomized checks of shield_read_decrypt_arbiter against a
// transaction-level round-robin model; honours SHIELD_DECRYPT_ARB_STATS_EN.
module tb_shield_read_decrypt_arbiter;
  localparam int N = 4, LW = 512, AW = 32, CW = 32, IW = 64, TW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*LW-1:0] up_req_data = '0;
  logic [N*AW-1:0] up_req_addr = '0;
  logic [N*CW-1:0] up_req_counter = '0;
  logic [N*IW-1:0] up_req_iv = '0;
  logic [N-1:0]    up_req_val = '0, up_req_rdy, up_resp_val, up_resp_rdy = '1;
  logic [LW-1:0]   up_resp_pad, dec_req_data, dec_resp_pad = '0;
  logic [TW-1:0]   up_resp_hmac_tag, dec_resp_hmac_tag = '0;
  logic [AW-1:0]   dec_req_addr;
  logic [CW-1:0]   dec_req_counter;
  logic [IW-1:0]   dec_req_iv;
  logic            dec_req_val, dec_req_rdy = 1'b1, dec_resp_val = 1'b0, dec_resp_rdy, busy;
  logic [N*32-1:0] stat_grants;

  always #5 clk = ~clk;

  shield_read_decrypt_arbiter #(.NUM_REQ(N), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_req_data(up_req_data), .up_req_addr(up_req_addr), .up_req_counter(up_req_counter),
    .up_req_iv(up_req_iv), .up_req_val(up_req_val), .up_req_rdy(up_req_rdy),
    .up_resp_pad(up_resp_pad), .up_resp_hmac_tag(up_resp_hmac_tag),
    .up_resp_val(up_resp_val), .up_resp_rdy(up_resp_rdy),
    .dec_req_data(dec_req_data), .dec_req_addr(dec_req_addr), .dec_req_counter(dec_req_counter),
    .dec_req_iv(dec_req_iv), .dec_req_val(dec_req_val), .dec_req_rdy(dec_req_rdy),
    .dec_resp_pad(dec_resp_pad), .dec_resp_hmac_tag(dec_resp_hmac_tag),
    .dec_resp_val(dec_resp_val), .dec_resp_rdy(dec_resp_rdy),
    .busy(busy), .stat_grants(stat_grants)
  );

  // Requester slots, transaction model and decryptor model
  logic [LW-1:0] s_data[N];
  logic [AW-1:0] s_addr[N];
  logic [CW-1:0] s_cnt[N];
  logic [IW-1:0] s_iv[N];
  int rem[N], stat_m[N], wait_cnt[N];
  int phase = 0, g = 0, last = N - 1;
  int glog[$];
  logic [N-1:0] prev_pend = '0, resp_rdy_fixed = '1;
  bit rand_mode = 0;
  int dm_wait = -1;
  logic [LW-1:0] dm_data, exp_pad;
  logic [AW-1:0] dm_addr, hs_addr;
  logic [CW-1:0] dm_cnt, hs_cnt;
  logic [IW-1:0] dm_iv;
  logic [TW-1:0] exp_tag;
  int cyc = 0, hs_cyc = 0, t0 = 0, n = 0;
  logic snap_busy, snap_drr, snap_dreq;
  logic [N-1:0] snap_urr, snap_urv;
  int checks = 0, passes = 0;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [LW-1:0] mk_pad(input logic [LW-1:0] d, input logic [CW-1:0] c,
                                           input logic [IW-1:0] iv);
    return d ^ {8{iv}} ^ {16{c}};
  endfunction

  function automatic int rr(input int from, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic drive_slots();
    for (int i = 0; i < N; i++) begin
      up_req_data[i*LW +: LW]    = s_data[i];
      up_req_addr[i*AW +: AW]    = s_addr[i];
      up_req_counter[i*CW +: CW] = s_cnt[i];
      up_req_iv[i*IW +: IW]      = s_iv[i];
    end
  endtask

  task automatic new_fields(input int i);
    for (int j = 0; j < LW / 32; j++) s_data[i][j*32 +: 32] = $urandom();
    s_addr[i] = $urandom();
    s_cnt[i]  = $urandom();
    s_iv[i]   = {$urandom(), $urandom()};
  endtask

  task automatic post(input int i, input int cnt, input logic [AW-1:0] a, input logic [CW-1:0] c);
    rem[i] = cnt;
    new_fields(i);
    s_addr[i] = a;
    s_cnt[i]  = c;
    up_req_val[i] = 1'b1;
    drive_slots();
  endtask

  task automatic cycle();
    logic req_hs, resp_hs, edge_rst, e_dreq, e_drr, fair_ok;
    logic [N-1:0] up_hs, e_urr, e_urv, one_g;
    logic [N*32-1:0] e_stat;
    int nxt;
    cyc++;
    @(negedge clk);
    snap_busy = busy; snap_drr = dec_resp_rdy; snap_dreq = dec_req_val;
    snap_urr = up_req_rdy; snap_urv = up_resp_val;
    req_hs  = dec_req_val && dec_req_rdy;
    resp_hs = dec_resp_val && dec_resp_rdy;
    up_hs   = up_req_val & up_req_rdy;
    chk("hold_val", up_req_val & prev_pend, prev_pend);
    prev_pend = up_req_val & ~up_req_rdy;
    one_g  = N'(1) << g;
    e_dreq = 1'b0; e_drr = 1'b0; e_urr = '0; e_urv = '0;
    if (phase == 1) begin
      e_dreq = up_req_val[g];
      e_urr  = dec_req_rdy ? one_g : '0;
    end else if (phase == 2) begin
      e_drr = up_resp_rdy[g];
      e_urv = dec_resp_val ? one_g : '0;
    end
    chk("ctrl", {busy, dec_req_val, dec_resp_rdy, up_req_rdy, up_resp_val},
        {phase != 0, e_dreq, e_drr, e_urr, e_urv});
    if (phase == 1 && dec_req_val)
      chk("fields", {dec_req_addr, dec_req_counter, dec_req_iv, dec_req_data},
          {s_addr[g], s_cnt[g], s_iv[g], s_data[g]});
    if (phase == 2 && resp_hs) begin
      chk("pad", up_resp_pad, exp_pad);
      chk("tag", up_resp_hmac_tag, exp_tag);
    end
    e_stat = '0;
`ifdef SHIELD_DECRYPT_ARB_STATS_EN
    for (int i = 0; i < N; i++) e_stat[i*32 +: 32] = 32'(stat_m[i]);
`endif
    chk("stats", stat_grants, e_stat);
    nxt = phase;
    if (phase == 0 && rst_n && |up_req_val) begin
      g = rr(last, up_req_val);
      nxt = 1;
    end
    if (phase == 1 && req_hs) begin
      nxt = 2;
      glog.push_back(g);
      stat_m[g]++;
      fair_ok = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (i == g || !up_req_val[i]) wait_cnt[i] = 0;
        else wait_cnt[i]++;
        if (wait_cnt[i] > N - 1) fair_ok = 1'b0;
      end
      chk("fairness", fair_ok, 1'b1);
      hs_cyc = cyc; hs_addr = dec_req_addr; hs_cnt = dec_req_counter;
      dm_data = dec_req_data; dm_addr = dec_req_addr; dm_cnt = dec_req_counter; dm_iv = dec_req_iv;
      exp_pad = mk_pad(s_data[g], s_cnt[g], s_iv[g]);
      exp_tag = {s_addr[g], s_cnt[g], s_iv[g]};
    end
    if (phase == 2 && resp_hs) begin
      last = g;
      nxt = 0;
    end
    phase = nxt;

    @(posedge clk);
    #1;
    edge_rst = !rst_n;
    for (int i = 0; i < N; i++) begin
      if (up_hs[i]) begin
        rem[i]--;
        if (rem[i] > 0) new_fields(i);
        else up_req_val[i] = 1'b0;
      end
      if (rand_mode && !up_req_val[i] && $urandom_range(0, 5) == 0)
        post(i, int'($urandom_range(1, 2)), $urandom(), $urandom());
    end
    drive_slots();
    if (resp_hs) dec_resp_val = 1'b0;
    if (req_hs) dm_wait = rand_mode ? int'($urandom_range(0, 3)) : 1;
    if (dm_wait == 0) begin
      dec_resp_val      = 1'b1;
      dec_resp_pad      = mk_pad(dm_data, dm_cnt, dm_iv);
      dec_resp_hmac_tag = {dm_addr, dm_cnt, dm_iv};
      dm_wait = -1;
    end else if (dm_wait > 0) begin
      dm_wait--;
    end
    if (edge_rst) begin
      phase = 0; last = N - 1; dm_wait = -1; dec_resp_val = 1'b0;
      for (int i = 0; i < N; i++) begin stat_m[i] = 0; wait_cnt[i] = 0; end
    end
    dec_req_rdy = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    up_resp_rdy = rand_mode ? N'($urandom()) : resp_rdy_fixed;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while ((phase != 0 || up_req_val != '0) && k < bound) begin
      cycle();
      k++;
    end
    chk("idle_timeout", k < bound, 1'b1);
  endtask

  task automatic wait_wait_phase(input int bound);
    int k;
    k = 0;
    while (phase != 2 && k < bound) begin
      cycle();
      k++;
    end
    chk("wait_timeout", k < bound, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; stat_m[i] = 0; wait_cnt[i] = 0;
      new_fields(i);
    end
    drive_slots();

    // Reset state
    do_reset();
    cycle();
    chk("rst_busy", snap_busy, 1'b0);
    chk("rst_urr", snap_urr, '0);
    chk("rst_urv", snap_urv, '0);
    chk("rst_dreq", snap_dreq, 1'b0);
    chk("rst_stats", stat_grants, '0);

    // Single request from requester 2
    glog.delete();
    post(2, 1, 32'h1000, 32'd5);
    t0 = cyc;
    wait_idle(50);
    chk("t1_count", glog.size(), 1);
    chk("t1_grant", glog[0], 2);
    chk("t1_latency", hs_cyc - t0, 2);
    chk("t1_addr", hs_addr, 32'h1000);
    chk("t1_counter", hs_cnt, 32'd5);

    // All four requesting continuously from reset
    do_reset();
    glog.delete();
    post(0, 2, $urandom(), $urandom());
    for (int i = 1; i < N; i++) post(i, 1, $urandom(), $urandom());
    wait_idle(200);
    chk("t2_count", glog.size(), 5);
    for (int k = 0; k < 5; k++) chk("t2_order", glog[k], k % N);

    // Requester 1 re-requests while 3 pending
    do_reset();
    glog.delete();
    post(1, 2, $urandom(), $urandom());
    post(3, 1, $urandom(), $urandom());
    wait_idle(100);
    chk("t3_count", glog.size(), 3);
    chk("t3_g0", glog[0], 1);
    chk("t3_g1", glog[1], 3);
    chk("t3_g2", glog[2], 1);

    // Owner stalls its response for 10 cycles (last grant was 1, so 2 wins)
    glog.delete();
    resp_rdy_fixed = 4'b1011;
    up_resp_rdy = resp_rdy_fixed;
    post(0, 1, $urandom(), $urandom());
    post(2, 1, $urandom(), $urandom());
    wait_wait_phase(20);
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("t4_drr", snap_drr, 1'b0);
      chk("t4_busy", snap_busy, 1'b1);
      chk("t4_urr", snap_urr, '0);
    end
    resp_rdy_fixed = '1;
    up_resp_rdy = '1;
    wait_idle(100);
    chk("t4_g0", glog[0], 2);
    chk("t4_g1", glog[1], 0);

    // Reset while in WAIT
    resp_rdy_fixed = '0;
    up_resp_rdy = '0;
    post(0, 2, $urandom(), $urandom());
    for (int i = 1; i < N; i++) post(i, 1, $urandom(), $urandom());
    wait_wait_phase(20);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    resp_rdy_fixed = '1;
    up_resp_rdy = '1;
    glog.delete();
    cycle();
    chk("t5_busy", snap_busy, 1'b0);
    chk("t5_outs", {snap_dreq, snap_drr, snap_urr, snap_urv}, '0);
    wait_idle(200);
    chk("t5_first", glog[0], 0);

    // Grant statistics over pattern 0,1,0,2,0,1
    do_reset();
    foreach (glog[k]) glog[k] = 0;
    begin
      int pat[6] = '{0, 1, 0, 2, 0, 1};
      for (int k = 0; k < 6; k++) begin
        post(pat[k], 1, $urandom(), $urandom());
        wait_idle(50);
      end
    end
    cycle();
    begin
      int exp_cnt[N] = '{3, 2, 1, 0};
      for (int i = 0; i < N; i++)
`ifdef SHIELD_DECRYPT_ARB_STATS_EN
        chk("t6_stat", stat_grants[i*32 +: 32], exp_cnt[i]);
`else
        chk("t6_stat", stat_grants[i*32 +: 32] + 32'(exp_cnt[i] * 0), 32'd0);
`endif
    end

    // Randomized traffic with random backpressure and decryptor latency
    rand_mode = 1;
    for (int k = 0; k < 600; k++) cycle();
    rand_mode = 0;
    resp_rdy_fixed = '1;
    wait_idle(300);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
